// File: rtl/nes_joypad_port.sv
// Two-player NES joypad port: USB keycodes -> two 8-button pads, served over the
// $4016/$4017 strobe / serial-read protocol with turbo, SOCD cleanup and post-8 fill.
module nes_joypad_port #(
    parameter int          NUM_KEYS     = 6,
    parameter logic [63:0] P1_MAP       = 64'h0A0B171C1A160407,
    parameter logic [63:0] P2_MAP       = 64'h0E0F180C5251504F,
    parameter logic [15:0] P1_TURBO     = 16'h1509,
    parameter logic [15:0] P2_TURBO     = 16'h1213,
    parameter int          TURBO_FRAMES = 2,
    parameter bit          SOCD_CLEAN   = 1'b1,
    parameter logic [7:0]  OPEN_BUS     = 8'h40
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  logic                  frame_tick,
    input  logic                  ENABLE,
    input  logic                  WR,
    input  logic                  addr0,
    input  logic [7:0]            bus,
    output logic [7:0]            DATA
);

    localparam int CW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
    localparam logic [CW-1:0] TURBO_LAST = CW'(TURBO_FRAMES - 1);

    logic [CW-1:0] turbo_cnt;
    logic          phase;
    logic          strobe;
    logic [7:0]    p1_q, p2_q;
    logic [7:0]    p1_next, p2_next;
    logic [7:0]    sh1, sh2;
    logic          wr_strobe, rd, load, rd_bit;
    logic          unused_bus;

    assign unused_bus = ^bus[7:1];

    // Keycode 00 marks an empty slot and must never match a button.
    function automatic logic key_hit(input logic [8*NUM_KEYS-1:0] keys,
                                     input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        if (code != 8'h00) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (keys[8*i +: 8] == code) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Map byte b lands on pad bit b, so byte7 -> A (bit 7) ... byte0 -> Right (bit 0).
    function automatic logic [7:0] decode_pad(input logic [8*NUM_KEYS-1:0] keys,
                                              input logic [63:0] map,
                                              input logic [15:0] turbo,
                                              input logic ph);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = key_hit(keys, map[8*b +: 8]);
        v[7] = v[7] | (key_hit(keys, turbo[15:8]) & ph);
        v[6] = v[6] | (key_hit(keys, turbo[7:0]) & ph);
        if (SOCD_CLEAN) begin
            if (v[3] & v[2]) v[3:2] = 2'b00;
            if (v[1] & v[0]) v[1:0] = 2'b00;
        end
        return v;
    endfunction

    always_comb begin
        p1_next = decode_pad(keycodes, P1_MAP, P1_TURBO, phase);
        p2_next = decode_pad(keycodes, P2_MAP, P2_TURBO, phase);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            turbo_cnt <= '0;
            phase     <= 1'b0;
            p1_q      <= 8'h00;
            p2_q      <= 8'h00;
        end else begin
            p1_q <= p1_next;
            p2_q <= p2_next;
            if (frame_tick) begin
                if (turbo_cnt == TURBO_LAST) begin
                    turbo_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    turbo_cnt <= turbo_cnt + 1'b1;
                end
            end
        end
    end

    // $4017 writes belong to the APU frame counter and never touch the strobe.
    assign wr_strobe = ENABLE & WR & ~addr0;
    assign rd        = ENABLE & ~WR;
    assign load      = strobe | (wr_strobe & bus[0]);

    always_comb begin
        rd_bit = 1'b1;
        if (strobe) rd_bit = addr0 ? p2_q[7] : p1_q[7];
        else        rd_bit = addr0 ? sh2[7]  : sh1[7];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe <= 1'b0;
            sh1    <= 8'hFF;
            sh2    <= 8'hFF;
            DATA   <= 8'h00;
        end else begin
            if (wr_strobe) strobe <= bus[0];
            if (load) begin
                sh1 <= p1_q;
                sh2 <= p2_q;
            end else if (rd) begin
                if (addr0) sh2 <= {sh2[6:0], 1'b1};
                else       sh1 <= {sh1[6:0], 1'b1};
            end
            if (rd) DATA <= {OPEN_BUS[7:1], rd_bit};
        end
    end

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed bench for nes_joypad_port; a second instance runs with SOCD cleanup disabled.
module tb_nes_joypad_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [47:0] keycodes = '0;
    logic        frame_tick = 1'b0;
    logic        ENABLE = 1'b0;
    logic        WR = 1'b0;
    logic        addr0 = 1'b0;
    logic [7:0]  bus = '0;
    logic [7:0]  DATA;
    logic [7:0]  DATA_ns;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    nes_joypad_port dut (
        .clk(clk), .reset_n(reset_n), .keycodes(keycodes), .frame_tick(frame_tick),
        .ENABLE(ENABLE), .WR(WR), .addr0(addr0), .bus(bus), .DATA(DATA)
    );

    nes_joypad_port #(.SOCD_CLEAN(1'b0)) dut_ns (
        .clk(clk), .reset_n(reset_n), .keycodes(keycodes), .frame_tick(frame_tick),
        .ENABLE(ENABLE), .WR(WR), .addr0(addr0), .bus(bus), .DATA(DATA_ns)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic a, input logic [7:0] d);
        ENABLE = 1'b1; WR = 1'b1; addr0 = a; bus = d;
        tick();
        ENABLE = 1'b0; WR = 1'b0;
    endtask

    task automatic do_read(input logic a);
        ENABLE = 1'b1; WR = 1'b0; addr0 = a;
        tick();
        ENABLE = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        checks++;
        if (DATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: DATA=%h expected 00", DATA);
        end
        reset_n = 1'b1;
        tick();
        do_read(1'b0);
        checks++;
        if (DATA !== 8'h41) begin
            failures++;
            $display("FAIL reset_sh_ff: DATA=%h expected 41", DATA);
        end
    endtask

    task automatic test_serial_read();
        logic [7:0] exp [10] = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h41,
                                 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
        keycodes = 48'h0000_0000_1A0A;
        tick();
        do_write(1'b0, 8'h01);
        do_write(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            do_read(1'b0);
            checks++;
            if (DATA !== exp[i]) begin
                failures++;
                $display("FAIL serial_read%0d: DATA=%h expected %h", i + 1, DATA, exp[i]);
            end
        end
    endtask

    task automatic test_strobe_held();
        logic [7:0] exp [5] = '{8'h41, 8'h41, 8'h41, 8'h40, 8'h40};
        keycodes = 48'h0000_0000_000A;
        tick();
        do_write(1'b0, 8'h01);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) keycodes = '0;
            do_read(1'b0);
            checks++;
            if (DATA !== exp[i]) begin
                failures++;
                $display("FAIL strobe_held%0d: DATA=%h expected %h", i, DATA, exp[i]);
            end
        end
        do_write(1'b0, 8'h00);
    endtask

    task automatic test_p2_interleaved();
        logic [7:0] exp [9] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h41,
                                8'h40, 8'h40, 8'h41, 8'h41};
        keycodes = 48'h0000_0000_524F;
        tick();
        do_write(1'b0, 8'h01);
        do_write(1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            do_read(1'b1);
            checks++;
            if (DATA !== exp[i]) begin
                failures++;
                $display("FAIL p2_read%0d: DATA=%h expected %h", i + 1, DATA, exp[i]);
            end
            if (i % 2 == 1) begin
                do_read(1'b0);
                checks++;
                if (DATA !== 8'h40) begin
                    failures++;
                    $display("FAIL p1_interleave%0d: DATA=%h expected 40", i, DATA);
                end
            end
        end
    endtask

    task automatic test_socd();
        logic [7:0] pads [2]    = '{8'b0000_0010, 8'b0000_0000};
        logic [7:0] pads_ns [2] = '{8'b0000_1110, 8'b0000_0011};
        logic [47:0] keys [2]   = '{48'h0000_0004_161A, 48'h0000_0000_0407};
        logic [7:0] p, pn;
        for (int s = 0; s < 2; s++) begin
            keycodes = keys[s];
            p  = pads[s];
            pn = pads_ns[s];
            tick();
            do_write(1'b0, 8'h01);
            do_write(1'b0, 8'h00);
            for (int i = 7; i >= 0; i--) begin
                do_read(1'b0);
                checks++;
                if (DATA !== {7'h20, p[i]}) begin
                    failures++;
                    $display("FAIL socd%0d_bit%0d: DATA=%h expected %h", s, i, DATA, {7'h20, p[i]});
                end
                checks++;
                if (DATA_ns !== {7'h20, pn[i]}) begin
                    failures++;
                    $display("FAIL nosocd%0d_bit%0d: DATA=%h expected %h", s, i, DATA_ns, {7'h20, pn[i]});
                end
            end
        end
    endtask

    task automatic test_turbo();
        logic [7:0] exp [8] = '{8'h40, 8'h40, 8'h41, 8'h41, 8'h40, 8'h40, 8'h41, 8'h41};
        logic [7:0] exp_co [3] = '{8'h41, 8'h41, 8'h40};
        keycodes = 48'h0000_0000_0015;
        tick();
        do_write(1'b0, 8'h01);
        tick();
        for (int f = 0; f < 8; f++) begin
            if (f > 0) begin
                frame_tick = 1'b1;
                tick();
                frame_tick = 1'b0;
                tick();
            end
            do_read(1'b0);
            checks++;
            if (DATA !== exp[f]) begin
                failures++;
                $display("FAIL turbo_frame%0d: DATA=%h expected %h", f, DATA, exp[f]);
            end
        end
        // Tick lands on the same edge as a read: the toggle shows up two reads later.
        for (int i = 0; i < 3; i++) begin
            frame_tick = (i == 0);
            do_read(1'b0);
            frame_tick = 1'b0;
            checks++;
            if (DATA !== exp_co[i]) begin
                failures++;
                $display("FAIL turbo_coincide%0d: DATA=%h expected %h", i, DATA, exp_co[i]);
            end
        end
        do_write(1'b0, 8'h00);
        keycodes = '0;
    endtask

    task automatic test_back_to_back();
        keycodes = 48'h0000_0000_1A0A;
        tick();
        do_write(1'b0, 8'h01);
        do_write(1'b0, 8'h00);
        do_read(1'b0);
        checks++;
        if (DATA !== 8'h41) begin
            failures++;
            $display("FAIL b2b_read1: DATA=%h expected 41", DATA);
        end
        do_write(1'b1, 8'h01);
        checks++;
        if (DATA !== 8'h41) begin
            failures++;
            $display("FAIL write_holds_data: DATA=%h expected 41", DATA);
        end
        do_read(1'b0);
        checks++;
        if (DATA !== 8'h40) begin
            failures++;
            $display("FAIL w4017_ignored: DATA=%h expected 40", DATA);
        end
        do_read(1'b0);
        checks++;
        if (DATA !== 8'h40) begin
            failures++;
            $display("FAIL b2b_read3: DATA=%h expected 40", DATA);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [3] = '{8'h41, 8'h40, 8'h40};
        keycodes = 48'h0000_0000_1A0A;
        tick();
        do_write(1'b0, 8'h01);
        do_write(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            do_read(1'b0);
            checks++;
            if (DATA !== exp[i]) begin
                failures++;
                $display("FAIL mid_read%0d: DATA=%h expected %h", i + 1, DATA, exp[i]);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (DATA !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_async: DATA=%h expected 00", DATA);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_read(1'b0);
            checks++;
            if (DATA !== 8'h41) begin
                failures++;
                $display("FAIL post_reset_read%0d: DATA=%h expected 41", i, DATA);
            end
        end
    endtask

    initial begin
        test_reset();
        test_serial_read();
        test_strobe_held();
        test_p2_interleaved();
        test_socd();
        test_turbo();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
